sweep_sequencer: RTL and testbench

- Per-point measurement scheduler for the VNA sweep. For each frequency point it pulses a step request to the source, waits a settle time, then gates the shared I/Q accumulators with one enable for a programmed integration window.
- After the accumulators drain, it captures their totals and presents them downstream with a valid/ready handshake.
- Sits between the PS configuration registers and the accumulator/readout datapath.

---
 rtl/sweep_sequencer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_sweep_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_sequencer.sv
// ---------------------------------------------------------------------------------------------
// sweep_sequencer
//
// Per-point measurement scheduler for the VNA sweep. For every frequency point it pulses a step
// request to the source, waits a programmable settle time, opens the shared I/Q accumulators for
// a programmed integration window, waits for the accumulators to drain, captures their totals
// and offers them downstream on a valid/ready handshake. The next point only starts once the
// current result has been accepted, so points never overlap.
//
// Ports
//   aclk, rst                 clock (rising edge) and asynchronous active-high reset
//   cfg_start / cfg_abort     start pulse (IDLE only) and abort (any state, wins over all else)
//   cfg_num_points            points per sweep (0 gives an empty sweep that just reports done)
//   cfg_settle_cycles         settle wait after each step pulse (0 skips the settle phase)
//   cfg_int_cycles            acc_enable high cycles per point (0 is treated as 1)
//   step_out                  one-cycle pulse: advance the source to the next frequency
//   acc_enable                accumulator enable, high for exactly the integration window
//   acc_i/q_value, acc_count  accumulator totals, sampled on the last drain cycle
//   res_i/q, res_count        captured totals, held until accepted and after that until the
//                             next capture (abort leaves them untouched)
//   res_index                 0-based point index of the captured result
//   res_valid / res_ready     result handshake
//   busy                      high in every state except IDLE
//   sweep_done                one-cycle pulse after the last result has been accepted
//
// All control outputs are registered from the next state, so they change only on clock edges
// and are glitch-free towards the source and accumulators.
// DRAIN_CYCLES must be at least 1.
// ---------------------------------------------------------------------------------------------
module sweep_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned IDX_W        = 16
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic [IDX_W-1:0] cfg_num_points,
  input  logic [31:0]      cfg_settle_cycles,
  input  logic [31:0]      cfg_int_cycles,
  output logic             step_out,
  output logic             acc_enable,
  input  logic [63:0]      acc_i_value,
  input  logic [63:0]      acc_q_value,
  input  logic [31:0]      acc_count,
  output logic [63:0]      res_i,
  output logic [63:0]      res_q,
  output logic [31:0]      res_count,
  output logic [IDX_W-1:0] res_index,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             sweep_done
);

  localparam logic [31:0] DrainLast = 32'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StStep      = 3'd1,
    StSettle    = 3'd2,
    StIntegrate = 3'd3,
    StDrain     = 3'd4,
    StOutput    = 3'd5,
    StDone      = 3'd6
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  // Latched sweep configuration
  logic [IDX_W-1:0] r_num;
  logic [31:0]      r_settle;
  logic [31:0]      r_int;

  // Shared phase counter and point index
  logic [31:0]      r_cnt;
  logic [31:0]      w_cnt_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;

  // Registered outputs
  logic             r_step;
  logic             r_acc_en;
  logic             r_busy;
  logic             r_done;
  logic             r_res_valid;
  logic [63:0]      r_res_i;
  logic [63:0]      r_res_q;
  logic [31:0]      r_res_count;
  logic [IDX_W-1:0] r_res_index;

  logic             w_latch;
  logic             w_capture;
  logic [31:0]      w_int_eff;
  logic             w_settle_last;
  logic             w_int_last;
  logic             w_drain_last;
  logic [IDX_W:0]   w_idx_inc;
  logic             w_more_points;

  assign w_int_eff     = (cfg_int_cycles == 32'd0) ? 32'd1 : cfg_int_cycles;
  // Each phase counts 0 .. length-1; the counter is cleared on every phase entry.
  assign w_settle_last = (r_cnt == (r_settle - 32'd1));
  assign w_int_last    = (r_cnt == (r_int - 32'd1));
  assign w_drain_last  = (r_cnt == DrainLast);
  // One extra bit so index+1 cannot wrap before the compare.
  assign w_idx_inc     = {1'b0, r_idx} + {{IDX_W{1'b0}}, 1'b1};
  assign w_more_points = (w_idx_inc < {1'b0, r_num});

  // ---------------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_latch     = 1'b0;
    w_capture   = 1'b0;

    if (cfg_abort) begin
      // Abort beats start and the result handshake in the same cycle.
      w_state_nxt = StIdle;
      w_cnt_nxt   = 32'd0;
    end else begin
      case (r_state)
        StIdle: begin
          if (cfg_start) begin
            w_latch   = 1'b1;
            w_cnt_nxt = 32'd0;
            w_idx_nxt = '0;
            if (cfg_num_points == '0) begin
              w_state_nxt = StDone;
            end else begin
              w_state_nxt = StStep;
            end
          end
        end

        StStep: begin
          w_cnt_nxt = 32'd0;
          if (r_settle == 32'd0) begin
            w_state_nxt = StIntegrate;
          end else begin
            w_state_nxt = StSettle;
          end
        end

        StSettle: begin
          if (w_settle_last) begin
            w_state_nxt = StIntegrate;
            w_cnt_nxt   = 32'd0;
          end else begin
            w_cnt_nxt = r_cnt + 32'd1;
          end
        end

        StIntegrate: begin
          if (w_int_last) begin
            w_state_nxt = StDrain;
            w_cnt_nxt   = 32'd0;
          end else begin
            w_cnt_nxt = r_cnt + 32'd1;
          end
        end

        StDrain: begin
          if (w_drain_last) begin
            w_state_nxt = StOutput;
            w_cnt_nxt   = 32'd0;
            w_capture   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 32'd1;
          end
        end

        StOutput: begin
          // res_valid is always high in this state, so res_ready alone completes the handshake.
          if (res_ready) begin
            if (w_more_points) begin
              w_idx_nxt   = w_idx_inc[IDX_W-1:0];
              w_state_nxt = StStep;
            end else begin
              w_state_nxt = StDone;
            end
          end
        end

        StDone: begin
          w_state_nxt = StIdle;
        end

        default: begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = 32'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------------
  // State, counters and latched configuration
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= 32'd0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_num    <= '0;
      r_settle <= 32'd0;
      r_int    <= 32'd0;
    end else if (w_latch) begin
      r_num    <= cfg_num_points;
      r_settle <= cfg_settle_cycles;
      r_int    <= w_int_eff;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Result capture: data is only written on the last drain edge, so it survives abort and
  // stays frozen while downstream stalls.
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_res_i     <= 64'd0;
      r_res_q     <= 64'd0;
      r_res_count <= 32'd0;
      r_res_index <= '0;
    end else if (w_capture) begin
      r_res_i     <= acc_i_value;
      r_res_q     <= acc_q_value;
      r_res_count <= acc_count;
      r_res_index <= r_idx;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Moore outputs, registered from the next state
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_step      <= 1'b0;
      r_acc_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_step      <= (w_state_nxt == StStep);
      r_acc_en    <= (w_state_nxt == StIntegrate);
      r_busy      <= (w_state_nxt != StIdle);
      r_done      <= (w_state_nxt == StDone);
      r_res_valid <= (w_state_nxt == StOutput);
    end
  end

  assign step_out   = r_step;
  assign acc_enable = r_acc_en;
  assign busy       = r_busy;
  assign sweep_done = r_done;
  assign res_valid  = r_res_valid;
  assign res_i      = r_res_i;
  assign res_q      = r_res_q;
  assign res_count  = r_res_count;
  assign res_index  = r_res_index;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed bench for sweep_sequencer. Inputs change 1 time unit after a rising edge and outputs
// are sampled at the same point, so "cycle k" below is the cycle following the k-th edge.
module tb_sweep_sequencer;

  localparam int IDX_W = 16;

  logic             aclk;
  logic             rst;
  logic             cfg_start;
  logic             cfg_abort;
  logic [IDX_W-1:0] cfg_num_points;
  logic [31:0]      cfg_settle_cycles;
  logic [31:0]      cfg_int_cycles;
  logic             step_out;
  logic             acc_enable;
  logic [63:0]      acc_i_value;
  logic [63:0]      acc_q_value;
  logic [31:0]      acc_count;
  logic [63:0]      res_i;
  logic [63:0]      res_q;
  logic [31:0]      res_count;
  logic [IDX_W-1:0] res_index;
  logic             res_valid;
  logic             res_ready;
  logic             busy;
  logic             sweep_done;

  int total = 0;
  int bad   = 0;
  int n_step, n_acc, n_valid, n_done;

  sweep_sequencer #(
    .DRAIN_CYCLES(3),
    .IDX_W       (IDX_W)
  ) dut (
    .aclk             (aclk),
    .rst              (rst),
    .cfg_start        (cfg_start),
    .cfg_abort        (cfg_abort),
    .cfg_num_points   (cfg_num_points),
    .cfg_settle_cycles(cfg_settle_cycles),
    .cfg_int_cycles   (cfg_int_cycles),
    .step_out         (step_out),
    .acc_enable       (acc_enable),
    .acc_i_value      (acc_i_value),
    .acc_q_value      (acc_q_value),
    .acc_count        (acc_count),
    .res_i            (res_i),
    .res_q            (res_q),
    .res_count        (res_count),
    .res_index        (res_index),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .busy             (busy),
    .sweep_done       (sweep_done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and tally the pulses seen in the new cycle.
  task automatic tick();
    @(posedge aclk);
    #1;
    n_step  += int'(step_out);
    n_acc   += int'(acc_enable);
    n_valid += int'(res_valid);
    n_done  += int'(sweep_done);
  endtask

  task automatic clr_counts();
    n_step  = 0;
    n_acc   = 0;
    n_valid = 0;
    n_done  = 0;
  endtask

  // Start pulse in the current cycle; returns in the cycle after it was sampled.
  task automatic start_sweep(input logic [IDX_W-1:0] num, input logic [31:0] settle,
                             input logic [31:0] icyc);
    cfg_num_points    = num;
    cfg_settle_cycles = settle;
    cfg_int_cycles    = icyc;
    cfg_start         = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 200) begin
      tick();
      k++;
    end
    chk(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [15:0] step_h, acc_h, valid_h, done_h, busy_h;
    logic [IDX_W-1:0] idx_at_valid;
    logic [63:0] snap_i;
    logic [IDX_W-1:0] snap_idx;
    logic stall_ok;
    int k;

    rst               = 1'b0;
    cfg_start         = 1'b0;
    cfg_abort         = 1'b0;
    cfg_num_points    = '0;
    cfg_settle_cycles = 32'd0;
    cfg_int_cycles    = 32'd0;
    acc_i_value       = 64'd0;
    acc_q_value       = 64'd0;
    acc_count         = 32'd0;
    res_ready         = 1'b0;
    clr_counts();

    // ---- reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_step", 64'(step_out), 64'd0);
    chk("rst_acc", 64'(acc_enable), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_res_i", res_i, 64'd0);
    #9 rst = 1'b0;
    tick();
    tick();

    // ---- single point: num=1 settle=2 int=4, ready tied high
    res_ready   = 1'b1;
    acc_i_value = 64'h55;
    step_h = '0; acc_h = '0; valid_h = '0; done_h = '0; busy_h = '0;
    idx_at_valid = '1;
    start_sweep(16'd1, 32'd2, 32'd4);
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) tick();
      step_h[c]  = step_out;
      acc_h[c]   = acc_enable;
      valid_h[c] = res_valid;
      done_h[c]  = sweep_done;
      busy_h[c]  = busy;
      if (c == 11) idx_at_valid = res_index;
    end
    chk("t1_step_timing", 64'(step_h), 64'h0002);
    chk("t1_acc_timing", 64'(acc_h), 64'h00F0);
    chk("t1_valid_timing", 64'(valid_h), 64'h0800);
    chk("t1_done_timing", 64'(done_h), 64'h1000);
    chk("t1_busy_timing", 64'(busy_h), 64'h1FFE);
    chk("t1_index", 64'(idx_at_valid), 64'd0);
    chk("t1_res_i", res_i, 64'h55);

    // ---- three points with a 5-cycle stall on each; a mid-sweep start must be ignored
    res_ready = 1'b0;
    clr_counts();
    start_sweep(16'd3, 32'd1, 32'd2);
    for (int p = 0; p < 3; p++) begin
      k = 0;
      while (!res_valid && k < 100) begin
        tick();
        k++;
      end
      chk("t2_valid_seen", 64'(res_valid), 64'd1);
      chk("t2_index", 64'(res_index), 64'(p));
      snap_i   = res_i;
      snap_idx = res_index;
      stall_ok = 1'b1;
      for (int s = 0; s < 5; s++) begin
        if (p == 1 && s == 0) begin
          cfg_num_points = 16'd7;
          cfg_start      = 1'b1;
        end
        acc_i_value = acc_i_value + 64'h1111;
        tick();
        cfg_start = 1'b0;
        if (res_i !== snap_i || res_index !== snap_idx || res_valid !== 1'b1 ||
            step_out !== 1'b0) stall_ok = 1'b0;
      end
      chk("t2_stall_stable", 64'(stall_ok), 64'd1);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("t2_valid_drop", 64'(res_valid), 64'd0);
    end
    wait_idle("t2_idle");
    chk("t2_step_count", 64'(n_step), 64'd3);
    chk("t2_done_count", 64'(n_done), 64'd1);
    chk("t2_acc_count", 64'(n_acc), 64'd6);

    // ---- num=0: one busy/done cycle, nothing else
    res_ready = 1'b1;
    clr_counts();
    start_sweep(16'd0, 32'd2, 32'd4);
    chk("t3_num0_busy", 64'(busy), 64'd1);
    chk("t3_num0_done", 64'(sweep_done), 64'd1);
    tick();
    chk("t3_num0_idle", 64'(busy), 64'd0);
    chk("t3_num0_nostep", 64'(n_step + n_acc), 64'd0);

    // ---- settle=0: enable directly after the step pulse
    clr_counts();
    start_sweep(16'd1, 32'd0, 32'd3);
    chk("t3_s0_step", 64'(step_out), 64'd1);
    tick();
    chk("t3_s0_acc", 64'(acc_enable), 64'd1);
    wait_idle("t3_s0_idle");
    chk("t3_s0_acc_len", 64'(n_acc), 64'd3);

    // ---- int=0 behaves as a one-cycle window
    clr_counts();
    start_sweep(16'd1, 32'd1, 32'd0);
    wait_idle("t3_i0_idle");
    chk("t3_i0_acc_len", 64'(n_acc), 64'd1);
    chk("t3_i0_done", 64'(n_done), 64'd1);

    // ---- abort on the 5th integration cycle, then a clean rerun
    clr_counts();
    start_sweep(16'd2, 32'd1, 32'd10);
    k = 0;
    while (!acc_enable && k < 50) begin
      tick();
      k++;
    end
    for (int s = 0; s < 4; s++) tick();
    chk("t4_in_window", 64'(acc_enable), 64'd1);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    chk("t4_acc_low", 64'(acc_enable), 64'd0);
    chk("t4_busy_low", 64'(busy), 64'd0);
    for (int s = 0; s < 20; s++) tick();
    chk("t4_no_valid_done", 64'(n_valid + n_done), 64'd0);
    chk("t4_acc_len", 64'(n_acc), 64'd5);
    clr_counts();
    start_sweep(16'd1, 32'd2, 32'd4);
    wait_idle("t4_rerun_idle");
    chk("t4_rerun", {32'(n_step), 32'(n_done)}, {32'd1, 32'd1});

    // ---- capture data: correct values are present only during the last drain cycle
    res_ready   = 1'b0;
    acc_i_value = 64'hDEAD;
    acc_q_value = 64'hBEEF;
    acc_count   = 32'd99;
    start_sweep(16'd1, 32'd2, 32'd4);
    for (int s = 0; s < 9; s++) tick();
    acc_i_value = 64'h1_0000_0005;
    acc_q_value = 64'hFFFF_FFFF_FFFF_FFFD;
    acc_count   = 32'd7;
    tick();
    acc_i_value = 64'h1234;
    acc_q_value = 64'h5678;
    acc_count   = 32'd42;
    chk("t5_valid", 64'(res_valid), 64'd1);
    chk("t5_res_i", res_i, 64'h1_0000_0005);
    chk("t5_res_q", res_q, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("t5_res_count", 64'(res_count), 64'd7);
    tick();
    chk("t5_hold", {res_i[31:0], res_count}, {32'h5, 32'd7});

    // ---- async reset while a result is pending
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", 64'(res_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_res_i", res_i, 64'd0);
    chk("t6_res_q", res_q, 64'd0);
    chk("t6_res_count", 64'(res_count), 64'd0);
    #2 rst = 1'b0;
    tick();
    chk("t6_stays_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
